shift_engine: RTL and testbench

Parametrised full-duplex shift engine generalising the single-direction SISO register: accepts a DW-bit parallel word over a valid/ready handshake, shifts it out serially while shifting a serial input in, and presents the received word in parallel with a one-cycle done pulse. Shift direction is selectable per transfer. A bit-strobe enable paces shifting. It sits between the register-file/datapath side and any bit-serial link (SPI-like or test serial chains) in the design.

---
 rtl/shift_engine.sv | 134 +++++++++++++
 tb/tb_shift_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// Full-duplex shift engine: loads a DW-bit word, shifts it out on sout while shifting sin in, then presents rx_data.
// Latency: load at edge 0, shifts on strobed edges, done pulse the cycle after the DW-th strobe, ld_ready one cycle later.
// Backpressure: ld_ready is high only in IDLE; ld_valid elsewhere is ignored, and enb=0 stalls the shift in place.
//
// Ports: clk/rst (async active-low), enb bit strobe, clr sync abort,
//        ld_valid/ld_ready/ld_data/ld_dir load handshake, sin/sout serial pair,
//        busy/done status, rx_data received word, bits_left remaining shifts,
//        rot rotate-mode select (only when SHIFT_ENGINE_ROTATE_EN is defined).
module shift_engine #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          clr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_dir,
  input  logic          sin,
  output logic          sout,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rx_data,
  output logic [CW-1:0] bits_left
`ifdef SHIFT_ENGINE_ROTATE_EN
  ,
  input  logic          rot
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] sh_q;
  logic [DW-1:0] rx_q;
  logic [CW-1:0] bits_left_q;
  logic          dir_q;       // 1 = right (LSB first), 0 = left (MSB first)
  logic          out_bit;
  logic          in_bit;
  logic          last_shift;

  // The bit leaving the register this strobe; also the rotate feedback bit.
  assign out_bit = dir_q ? sh_q[0] : sh_q[DW-1];

`ifdef SHIFT_ENGINE_ROTATE_EN
  logic rot_q;
  assign in_bit = rot_q ? out_bit : sin;
`else
  assign in_bit = sin;
`endif

  assign last_shift = (bits_left_q == CW'(1)) && enb;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clr overrides everything
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ld_valid)   state_d = SHIFT;
        SHIFT:   if (last_shift) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q        <= '0;
      rx_q        <= '0;
      bits_left_q <= '0;
      dir_q       <= 1'b0;
`ifdef SHIFT_ENGINE_ROTATE_EN
      rot_q       <= 1'b0;
`endif
    end else if (clr) begin
      // Abort keeps rx_data: it always reflects the last completed transfer.
      bits_left_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_valid) begin
            sh_q        <= ld_data;
            dir_q       <= ld_dir;
            bits_left_q <= CW'(DW);
`ifdef SHIFT_ENGINE_ROTATE_EN
            rot_q       <= rot;
`endif
          end
        end
        SHIFT: begin
          if (enb) begin
            if (dir_q) begin
              sh_q <= {in_bit, sh_q[DW-1:1]};
              if (last_shift) rx_q <= {in_bit, sh_q[DW-1:1]};
            end else begin
              sh_q <= {sh_q[DW-2:0], in_bit};
              if (last_shift) rx_q <= {sh_q[DW-2:0], in_bit};
            end
            bits_left_q <= bits_left_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decoded from registered state only
  assign ld_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sout      = (state_q == SHIFT) ? out_bit : 1'b0;
  assign rx_data   = rx_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed and randomized transfers against a word-level model.
// Latency: checks done timing as (shifts x strobe period) edges after load plus one.
// Backpressure: drives spurious ld_valid while busy and expects it to be ignored.
module tb_shift_engine;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);

  logic          clk;
  logic          rst;
  logic          enb;
  logic          clr;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_dir;
  logic          sin;
  logic          sout;
  logic          busy;
  logic          done;
  logic [DW-1:0] rx_data;
  logic [CW-1:0] bits_left;
  logic          rot;

  int n_vec;
  int n_bad;
  logic [DW-1:0] exp_rx;   // model of the last completed received word

  shift_engine #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .clr       (clr),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_dir    (ld_dir),
    .sin       (sin),
    .sout      (sout),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .bits_left (bits_left)
`ifdef SHIFT_ENGINE_ROTATE_EN
    ,
    .rot       (rot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer. p = strobe period in cycles; clr_at > 0 aborts when bits_left == clr_at.
  // Model: the i-th shifted-in bit lands at position i (right) or DW-1-i (left),
  // so driving sw in that order makes the received word equal sw; rotate returns data.
  task automatic xfer(input logic [DW-1:0] data, input logic dir, input logic [DW-1:0] sw,
                      input int p, input int clr_at, input logic r);
    int k;
    int edges;
    logic e;
    logic exp_out;
    logic [DW-1:0] want;
    want = r ? data : sw;
    chk("ld_ready_idle", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_dir   = dir;
    rot      = r;
    clr      = 1'b0;
    enb      = 1'($urandom);
    step();
    // Load-time fields are sampled once; scramble them to prove it.
    ld_data = DW'($urandom);
    ld_dir  = 1'($urandom);
    rot     = 1'($urandom);
    k = 0;
    edges = 0;
    while (k < DW && edges < DW * p + 20) begin
      exp_out = dir ? data[k] : data[DW-1-k];
      chk("sout", {31'd0, sout}, {31'd0, exp_out});
      chk("bits_left", {{(32-CW){1'b0}}, bits_left}, DW - k);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("done_low", {31'd0, done}, 32'd0);
      e = ((edges + 1) % p) == 0;
      enb = e;
      sin = e ? (dir ? sw[k] : sw[DW-1-k]) : 1'($urandom);
      ld_valid = 1'($urandom);
      if (clr_at > 0 && (DW - k) == clr_at) begin
        clr = 1'b1;
        enb = 1'b1;
        ld_valid = 1'b1;
        step();
        clr = 1'b0;
        enb = 1'b0;
        ld_valid = 1'b0;
        chk("clr_ready", {31'd0, ld_ready}, 32'd1);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_bits", {{(32-CW){1'b0}}, bits_left}, 32'd0);
        chk("clr_sout", {31'd0, sout}, 32'd0);
        chk("clr_rx", {{(32-DW){1'b0}}, rx_data}, {{(32-DW){1'b0}}, exp_rx});
        step();
        chk("clr_nodone", {31'd0, done}, 32'd0);
        chk("clr_idle", {31'd0, ld_ready}, 32'd1);
        return;
      end
      step();
      edges++;
      if (e) k++;
    end
    if (k < DW) chk("timeout", k, DW);
    chk("done_latency", edges, DW * p);
    ld_valid = 1'b0;
    enb = 1'($urandom);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd1);
    chk("done_ready", {31'd0, ld_ready}, 32'd0);
    chk("done_sout", {31'd0, sout}, 32'd0);
    chk("done_bits", {{(32-CW){1'b0}}, bits_left}, 32'd0);
    chk("rx_data", {{(32-DW){1'b0}}, rx_data}, {{(32-DW){1'b0}}, want});
    exp_rx = want;
    step();
    chk("done_once", {31'd0, done}, 32'd0);
    chk("ready_again", {31'd0, ld_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("rx_hold", {{(32-DW){1'b0}}, rx_data}, {{(32-DW){1'b0}}, exp_rx});
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    exp_rx   = '0;
    rst      = 1'b0;
    enb      = 1'b0;
    clr      = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_dir   = 1'b0;
    sin      = 1'b0;
    rot      = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sout", {31'd0, sout}, 32'd0);
    chk("rst_rx", {{(32-DW){1'b0}}, rx_data}, 32'd0);
    chk("rst_bits", {{(32-CW){1'b0}}, bits_left}, 32'd0);
    rst = 1'b1;
    step();

    xfer(8'hA5, 1'b1, 8'h3C, 1, 0, 1'b0);
    xfer(8'hC4, 1'b0, 8'h0F, 1, 0, 1'b0);
    xfer(DW'($urandom), 1'b1, DW'($urandom), 3, 0, 1'b0);
    xfer(DW'($urandom), 1'b1, DW'($urandom), 1, 4, 1'b0);
    xfer(DW'($urandom), 1'b0, DW'($urandom), 2, 4, 1'b0);
`ifdef SHIFT_ENGINE_ROTATE_EN
    xfer(8'h5A, 1'b1, 8'hFF, 1, 0, 1'b1);
`endif

    // Asynchronous reset in the middle of a transfer
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    ld_dir   = 1'b1;
    step();
    ld_valid = 1'b0;
    enb = 1'b1;
    sin = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    exp_rx = '0;
    #2;
    chk("mid_rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_sout", {31'd0, sout}, 32'd0);
    chk("mid_rst_rx", {{(32-DW){1'b0}}, rx_data}, 32'd0);
    chk("mid_rst_bits", {{(32-CW){1'b0}}, bits_left}, 32'd0);
    #1;
    rst = 1'b1;
    enb = 1'b0;
    step();
    chk("post_rst_done", {31'd0, done}, 32'd0);

    for (int t = 0; t < 24; t++) begin
      xfer(DW'($urandom), 1'($urandom), DW'($urandom), int'($urandom_range(1, 3)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW)) : 0,
`ifdef SHIFT_ENGINE_ROTATE_EN
           1'($urandom)
`else
           1'b0
`endif
          );
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
